// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data-memory controller slice.
package data_mem_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_WAIT = 3'd1,
      RMW_RD  = 3'd2,
      RMW_WR  = 3'd3,
      WR_WAIT = 3'd4,
      DONE    = 3'd5
   } state_t;

   localparam logic [2:0] SZ_BYTE  = 3'b001;
   localparam logic [2:0] SZ_HALF  = 3'b010;
   localparam logic [2:0] SZ_WORD  = 3'b100;
   localparam int         SIGN_BIT = 3;

   // Anything that is not a clean one-hot size is handled as a full word.
   function automatic logic [2:0] norm_size(input logic [2:0] sz);
      logic [2:0] res;
      case (sz)
         SZ_BYTE: res = SZ_BYTE;
         SZ_HALF: res = SZ_HALF;
         default: res = SZ_WORD;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/data_mem_lane.sv
// Lane steering: extracts/extends a load from a memory word and merges
// sub-word store data into a word for read-modify-write.
module data_mem_lane
   import data_mem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  byte_off,
   input  logic [3:0]  sign_mask,
   input  logic [31:0] wr_data,
   output logic [31:0] load_val,
   output logic [31:0] merged
);

   logic [2:0]  size;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic        sign_en;

   assign size     = norm_size(sign_mask[2:0]);
   assign sign_en  = sign_mask[SIGN_BIT];
   assign half_sel = byte_off[1] ? word[31:16] : word[15:0];

   always_comb begin
      byte_sel = word[7:0];
      case (byte_off)
         2'd1:    byte_sel = word[15:8];
         2'd2:    byte_sel = word[23:16];
         2'd3:    byte_sel = word[31:24];
         default: byte_sel = word[7:0];
      endcase
   end

   always_comb begin
      load_val = word;
      merged   = word;
      case (size)
         SZ_BYTE: begin
            load_val = {{24{sign_en & byte_sel[7]}}, byte_sel};
            merged[{byte_off, 3'b000} +: 8] = wr_data[7:0];
         end
         SZ_HALF: begin
            load_val = {{16{sign_en & half_sel[15]}}, half_sel};
            merged[{byte_off[1], 4'b0000} +: 16] = wr_data[15:0];
         end
         default: begin
            load_val = word;
            merged   = wr_data;
         end
      endcase
   end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller between the cpu MEM stage and a req/ack word memory.
// Optional misaligned-access trap is enabled with `define MISALIGN_TRAP_EN.
module data_mem_ctrl
   import data_mem_pkg::*;
#(
   parameter int          WORD_ADDR_W = 10,
   parameter logic [31:0] RESET_RDATA = 32'h0
)(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [31:0]            addr,
   input  logic [31:0]            wr_data,
   input  logic                   memwrite,
   input  logic                   memread,
   input  logic [3:0]             sign_mask,
   output logic [31:0]            read_data,
   output logic                   stall,
   output logic                   mem_req,
   output logic                   mem_we,
   output logic [WORD_ADDR_W-1:0] mem_addr,
   output logic [31:0]            mem_wdata,
   input  logic [31:0]            mem_rdata,
`ifdef MISALIGN_TRAP_EN
   output logic                   misaligned,
`endif
   input  logic                   mem_ack
);

   state_t      state, state_nxt;
   logic [31:0] rmw_word;
   logic [31:0] lane_word;
   logic [31:0] load_val;
   logic [31:0] merged_word;
   logic [2:0]  size;
   logic        waiting;
   logic        request;
   logic        mis_access;
   logic        unused_addr_bits;

   assign unused_addr_bits = ^addr[31:WORD_ADDR_W+2];
   assign size    = norm_size(sign_mask[2:0]);
   assign request = memwrite | memread;
   assign waiting = (state == RD_WAIT) || (state == RMW_RD) ||
                    (state == RMW_WR)  || (state == WR_WAIT);

`ifdef MISALIGN_TRAP_EN
   assign mis_access = ((size == SZ_HALF) && addr[0]) ||
                       ((size == SZ_WORD) && (addr[1:0] != 2'b00));
`else
   assign mis_access = 1'b0;
`endif

   // During the write half of an RMW the lane merge works on the latched word.
   assign lane_word = (state == RMW_WR) ? rmw_word : mem_rdata;

   data_mem_lane u_lane (
      .word      (lane_word),
      .byte_off  (addr[1:0]),
      .sign_mask (sign_mask),
      .wr_data   (wr_data),
      .load_val  (load_val),
      .merged    (merged_word)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (request) begin
               if (mis_access) begin
                  state_nxt = DONE;
               end else if (memwrite) begin
                  state_nxt = (size == SZ_WORD) ? WR_WAIT : RMW_RD;
               end else begin
                  state_nxt = RD_WAIT;
               end
            end
         end
         RD_WAIT: if (mem_ack) state_nxt = DONE;
         RMW_RD:  if (mem_ack) state_nxt = RMW_WR;
         RMW_WR:  if (mem_ack) state_nxt = DONE;
         WR_WAIT: if (mem_ack) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Memory-side outputs are decoded purely from state so reset drops them at once.
   always_comb begin
      stall     = ((state == IDLE) && request) || waiting;
      mem_req   = waiting;
      mem_we    = (state == RMW_WR) || (state == WR_WAIT);
      mem_addr  = '0;
      mem_wdata = '0;
      if (waiting) begin
         mem_addr = addr[WORD_ADDR_W+1:2];
      end
      if (state == WR_WAIT) begin
         mem_wdata = wr_data;
      end else if (state == RMW_WR) begin
         mem_wdata = merged_word;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rmw_word <= '0;
      end else if ((state == RMW_RD) && mem_ack) begin
         rmw_word <= mem_rdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         read_data <= RESET_RDATA;
      end else if ((state == RD_WAIT) && mem_ack) begin
         read_data <= load_val;
      end
   end

`ifdef MISALIGN_TRAP_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         misaligned <= 1'b0;
      end else begin
         misaligned <= (state == IDLE) && request && mis_access;
      end
   end
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl with a word-level memory model and
// cycle-by-cycle expectations derived from the access rules.
module tb_data_mem_ctrl;

   localparam int K_NONE = 0;
   localparam int K_LD   = 1;
   localparam int K_WST  = 2;
   localparam int K_SST  = 3;
   localparam int K_MIS  = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] addr, wr_data;
   logic        memwrite, memread;
   logic [3:0]  sign_mask;
   logic [31:0] read_data;
   logic        stall, mem_req, mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata, mem_rdata;
   logic        mem_ack;
`ifdef MISALIGN_TRAP_EN
   logic        misaligned;
`endif

   data_mem_ctrl #(.WORD_ADDR_W(10), .RESET_RDATA(32'h0)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .addr      (addr),
      .wr_data   (wr_data),
      .memwrite  (memwrite),
      .memread   (memread),
      .sign_mask (sign_mask),
      .read_data (read_data),
      .stall     (stall),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
`ifdef MISALIGN_TRAP_EN
      .misaligned(misaligned),
`endif
      .mem_ack   (mem_ack)
   );

   always #5 clk = ~clk;

   logic [31:0] mem     [0:1023];
   logic [31:0] ref_mem [0:1023];

   int checks = 0;
   int passes = 0;

   int          m_total = 0;
   int          m_idx   = 1;
   int          m_k     = 1;
   int          m_kind  = K_NONE;
   logic [31:0] m_wdata = 32'h0;
   logic [31:0] cur_addr = 32'h0;
   logic [31:0] exp_rd = 32'h0;
   logic [31:0] pend_rd = 32'h0;
   bit          pend_valid = 1'b0;
   bit          resp_en = 1'b1;
   int          r_cnt = 0;
   bit          prev_req = 1'b0;
   int          stall_seen = 0;
   int          req_rises = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [2:0] eff_size(input logic [3:0] sm);
      if ($countones(sm[2:0]) == 1) return sm[2:0];
      return 3'b100;
   endfunction

   function automatic bit is_mis(input logic [31:0] a, input logic [3:0] sm);
`ifdef MISALIGN_TRAP_EN
      logic [2:0] sz = eff_size(sm);
      return (sz == 3'b010 && a[0]) || (sz == 3'b100 && a[1:0] != 2'b00);
`else
      return 1'b0 & a[0] & sm[0];
`endif
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] w, input logic [31:0] a, input logic [3:0] sm);
      logic [2:0]  sz = eff_size(sm);
      logic [31:0] v;
      int          sh;
      if (sz == 3'b001) begin
         sh = a[1:0]; sh = sh * 8;
         v = (w >> sh) & 32'hFF;
         if (sm[3] && v >= 32'd128) v = v - 32'd256;
      end else if (sz == 3'b010) begin
         sh = a[1]; sh = sh * 16;
         v = (w >> sh) & 32'hFFFF;
         if (sm[3] && v >= 32'd32768) v = v - 32'd65536;
      end else begin
         v = w;
      end
      return v;
   endfunction

   function automatic logic [31:0] model_store(input logic [31:0] old, input logic [31:0] a,
                                               input logic [31:0] wd, input logic [3:0] sm);
      logic [2:0]  sz = eff_size(sm);
      logic [31:0] msk;
      int          sh;
      if (sz == 3'b001) begin
         sh = a[1:0]; sh = sh * 8;
         msk = 32'hFF << sh;
      end else if (sz == 3'b010) begin
         sh = a[1]; sh = sh * 16;
         msk = 32'hFFFF << sh;
      end else begin
         return wd;
      end
      return (old & ~msk) | ((wd << sh) & msk);
   endfunction

   task automatic preload(input int idx, input logic [31:0] val);
      mem[idx]     = val;
      ref_mem[idx] = val;
   endtask

   // One cycle: compare outputs against the model, then act as the memory.
   task automatic step();
      logic e_stall, e_req, e_we, e_mis;
      @(negedge clk);
      if (m_idx < m_total) begin
         e_stall = 1'b1;
         e_req   = (m_idx > 0) && (m_kind != K_MIS);
         e_we    = e_req && ((m_kind == K_WST) || (m_kind == K_SST && m_idx > m_k));
         e_mis   = 1'b0;
      end else begin
         e_stall = 1'b0;
         e_req   = 1'b0;
         e_we    = 1'b0;
         e_mis   = (m_idx == m_total) && (m_kind == K_MIS);
         if (m_idx == m_total && pend_valid) begin
            exp_rd     = pend_rd;
            pend_valid = 1'b0;
         end
      end
      checkOutput("stall", {31'b0, stall}, {31'b0, e_stall});
      checkOutput("mem_req", {31'b0, mem_req}, {31'b0, e_req});
      checkOutput("mem_we", {31'b0, mem_we}, {31'b0, e_we});
      checkOutput("read_data", read_data, exp_rd);
      if (e_req) checkOutput("mem_addr", {22'b0, mem_addr}, {22'b0, cur_addr[11:2]});
      if (e_we) checkOutput("mem_wdata", mem_wdata, m_wdata);
`ifdef MISALIGN_TRAP_EN
      checkOutput("misaligned", {31'b0, misaligned}, {31'b0, e_mis});
`else
      if (e_mis) checkOutput("misaligned_kind", 32'd1, 32'd0);
`endif
      m_idx++;
      stall_seen += int'(stall);
      if (mem_req && !prev_req) req_rises++;
      prev_req = mem_req;

      mem_rdata = 32'hDEADBEEF;
      if (mem_ack) begin
         mem_ack = 1'b0;
         r_cnt   = 0;
      end
      if (resp_en && mem_req) begin
         r_cnt++;
         if (r_cnt == m_k) begin
            mem_ack = 1'b1;
            if (mem_we) mem[mem_addr] = mem_wdata;
            else        mem_rdata = mem[mem_addr];
         end
      end else if (!mem_req) begin
         r_cnt = 0;
      end
   endtask

   task automatic setModel(input logic we, input logic re, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] sm, input int k);
      cur_addr   = a;
      m_k        = k;
      pend_valid = 1'b0;
      if (!we && !re) begin
         m_kind = K_NONE; m_total = 0;
      end else if (is_mis(a, sm)) begin
         m_kind = K_MIS; m_total = 1;
      end else if (we) begin
         if (eff_size(sm) == 3'b100) begin
            m_kind = K_WST; m_total = k + 1; m_wdata = wd;
         end else begin
            m_kind = K_SST; m_total = 2 * k + 1;
            m_wdata = model_store(ref_mem[a[11:2]], a, wd, sm);
         end
         ref_mem[a[11:2]] = m_wdata;
      end else begin
         m_kind = K_LD; m_total = k + 1;
         pend_rd = model_load(ref_mem[a[11:2]], a, sm);
         pend_valid = 1'b1;
      end
      m_idx = 0;
   endtask

   // Entered just after a rising edge; leaves just after the DONE->IDLE edge.
   task automatic applyStimulus(input logic we, input logic re, input logic [31:0] a,
                                input logic [31:0] wd, input logic [3:0] sm, input int k,
                                output int sc, output int rc);
      memwrite = we; memread = re; addr = a; wr_data = wd; sign_mask = sm;
      stall_seen = 0; req_rises = 0;
      setModel(we, re, a, wd, sm, k);
      repeat (m_total + 1) step();
      sc = stall_seen;
      rc = req_rises;
      if (we) checkOutput("mem_word", mem[a[11:2]], ref_mem[a[11:2]]);
      @(posedge clk); #1;
      memwrite = 1'b0; memread = 1'b0;
   endtask

   initial begin
      int sc, rc;
      rst_n = 1'b0; addr = '0; wr_data = '0; memwrite = 1'b0; memread = 1'b0;
      sign_mask = 4'b0100; mem_ack = 1'b0; mem_rdata = 32'h0;
      #3;
      checkOutput("rst_read_data", read_data, 32'h0);
      checkOutput("rst_stall", {31'b0, stall}, 32'h0);
      checkOutput("rst_mem_req", {31'b0, mem_req}, 32'h0);
      checkOutput("rst_mem_we", {31'b0, mem_we}, 32'h0);
      checkOutput("rst_mem_addr", {22'b0, mem_addr}, 32'h0);
      checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
      #9 rst_n = 1'b1;
      @(posedge clk); #1;

      preload(10'h041, 32'h1280_3456);
      preload(10'h050, 32'hAABB_CCDD);
      preload(10'h060, 32'h5566_7788);

      applyStimulus(1'b0, 1'b1, 32'h0000_0105, 32'h0, 4'b1001, 2, sc, rc);
      checkOutput("ldb_signed_pos", read_data, 32'h0000_0034);
      checkOutput("ldb_stall_cycles", sc, 32'd3);
      applyStimulus(1'b0, 1'b1, 32'h0000_0106, 32'h0, 4'b1001, 1, sc, rc);
      checkOutput("ldb_signed_neg", read_data, 32'hFFFF_FF80);
      applyStimulus(1'b0, 1'b1, 32'h0000_0106, 32'h0, 4'b0001, 3, sc, rc);
      checkOutput("ldb_unsigned", read_data, 32'h0000_0080);

      applyStimulus(1'b1, 1'b0, 32'h0000_0142, 32'h0000_1234, 4'b0010, 2, sc, rc);
      checkOutput("sth_word", mem[10'h050], 32'h1234_CCDD);
      checkOutput("sth_keeps_rd", read_data, 32'h0000_0080);
      checkOutput("sth_stall_cycles", sc, 32'd5);

      applyStimulus(1'b1, 1'b0, 32'h0000_0200, 32'hCAFE_F00D, 4'b0100, 1, sc, rc);
      checkOutput("stw_stall_cycles", sc, 32'd2);
      checkOutput("stw_req_count", rc, 32'd1);
      applyStimulus(1'b0, 1'b1, 32'h0000_0200, 32'h0, 4'b0100, 1, sc, rc);
      checkOutput("ldw_b2b", read_data, 32'hCAFE_F00D);

      applyStimulus(1'b1, 1'b0, 32'h0000_0143, 32'h0000_00EE, 4'b0001, 1, sc, rc);
      checkOutput("stb_word", mem[10'h050], 32'hEE34_CCDD);
      applyStimulus(1'b0, 1'b1, 32'h0000_0142, 32'h0, 4'b1010, 2, sc, rc);
      checkOutput("ldh_signed", read_data, 32'hFFFF_EE34);
      applyStimulus(1'b0, 1'b1, 32'h0000_0143, 32'h0, 4'b1010, 1, sc, rc);
      applyStimulus(1'b0, 1'b1, 32'h0000_0200, 32'h0, 4'b0011, 2, sc, rc);
      applyStimulus(1'b0, 1'b1, 32'h0000_0200, 32'h0, 4'b1000, 1, sc, rc);
      checkOutput("ld_badmask_word", read_data, 32'hCAFE_F00D);

      applyStimulus(1'b0, 1'b1, 32'h0000_0201, 32'h0, 4'b0100, 2, sc, rc);
`ifdef MISALIGN_TRAP_EN
      checkOutput("mis_stall_cycles", sc, 32'd1);
      checkOutput("mis_req_count", rc, 32'd0);
`else
      checkOutput("ldw_truncated", read_data, 32'hCAFE_F00D);
`endif

      applyStimulus(1'b1, 1'b1, 32'h0000_0204, 32'h1122_3344, 4'b0100, 2, sc, rc);
      checkOutput("wr_priority", mem[10'h081], 32'h1122_3344);
      applyStimulus(1'b0, 1'b0, 32'h0000_0204, 32'h0, 4'b0100, 1, sc, rc);

      // Abort a sub-word store while its write phase is still waiting for ack.
      memwrite = 1'b1; memread = 1'b0; addr = 32'h0000_0181;
      wr_data = 32'h0000_00AB; sign_mask = 4'b0001;
      setModel(1'b1, 1'b0, 32'h0000_0181, 32'h0000_00AB, 4'b0001, 4);
      ref_mem[10'h060] = 32'h5566_7788;
      repeat (7) step();
      #2 rst_n = 1'b0;
      #1;
      checkOutput("arst_mem_req", {31'b0, mem_req}, 32'h0);
      checkOutput("arst_mem_we", {31'b0, mem_we}, 32'h0);
      checkOutput("arst_read_data", read_data, 32'h0);
      exp_rd = 32'h0;
      memwrite = 1'b0; resp_en = 1'b0;
      @(posedge clk); #2 rst_n = 1'b1;
      m_kind = K_NONE; m_total = 0; m_idx = 1; pend_valid = 1'b0; r_cnt = 0;
      step();
      mem_ack = 1'b1;
      step();
      step();
      checkOutput("arst_mem_intact", mem[10'h060], 32'h5566_7788);
      resp_en = 1'b1;
      @(posedge clk); #1;
      applyStimulus(1'b0, 1'b1, 32'h0000_0181, 32'h0, 4'b0100, 2, sc, rc);
      checkOutput("post_rst_load", read_data, 32'h5566_7788);

      $display("[TB] %0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Data-memory controller directly downstream of the cpu MEM stage. It consumes the cpu data port (address, write data, memwrite, memread, sign_mask) and drives a single-port, word-wide, variable-latency memory through a req/ack handshake. Sub-word stores are done as read-modify-write. Sub-word loads are extracted and sign- or zero-extended. The block stalls the core until each access completes.

Parameters:
- WORD_ADDR_W, 10, word-address width toward memory; the byte address bits used are addr[WORD_ADDR_W+1:2].
- RESET_RDATA, 32'h0, reset value of read_data.

Ports:
- clk  in  1  core clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- addr  in  32  byte address from cpu (data_mem_addr).
- wr_data  in  32  store data, right-aligned (data_mem_WrData).
- memwrite  in  1  store request.
- memread  in  1  load request.
- sign_mask  in  4  [3] = sign-extend; [2:0] one-hot size: 001 byte, 010 half, 100 word.
- read_data  out  32  extended load result (to data_mem_out).
- stall  out  1  cpu must hold all request inputs stable while high.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write.
- mem_addr  out  WORD_ADDR_W  word address.
- mem_wdata  out  32  full write word.
- mem_rdata  in  32  read word; valid when mem_ack is high on a read.
- mem_ack  in  1  one-cycle completion pulse; may come 1..N cycles after mem_req rises.

Behaviour:
- States: IDLE, RD_WAIT, RMW_RD, RMW_WR, WR_WAIT, DONE. Reset state is IDLE.
- Reset values: read_data = RESET_RDATA; mem_req, mem_we, stall = 0; mem_addr, mem_wdata = 0.
- Reset asserted mid-operation: return to IDLE and drop mem_req immediately (asynchronous). A late mem_ack is ignored.
- IDLE, request decode (memwrite has priority if both memwrite and memread are high):
  - memread → RD_WAIT.
  - memwrite with word size → WR_WAIT.
  - memwrite with byte/half size → RMW_RD.
  - Neither → stay in IDLE.
- stall = (IDLE & (memread | memwrite)) | state ∈ {RD_WAIT, RMW_RD, RMW_WR, WR_WAIT}. stall is combinational, so it rises in the request cycle. It is low in DONE.
- In every waiting state, mem_req = 1 and mem_addr = addr[WORD_ADDR_W+1:2].
  - mem_we = 1 only in RMW_WR and WR_WAIT.
  - mem_wdata in WR_WAIT = wr_data.
  - mem_wdata in RMW_WR = the latched word with the target lane(s) replaced.
- State advance happens only on a cycle with mem_ack high:
  - RD_WAIT → DONE; read_data is updated in that same edge.
  - RMW_RD → RMW_WR; the word is latched.
  - RMW_WR → DONE.
  - WR_WAIT → DONE.
- mem_req drops in DONE, so there is at least one idle cycle between transactions.
- DONE → IDLE unconditionally. A request still asserted in IDLE starts a new access (the cpu advances on the DONE cycle).
- Latency with ack after k cycles:
  - Load: k+1 stall cycles.
  - Word store: k+1 stall cycles.
  - Sub-word store: 2k+1 stall cycles.
- Lanes: byte lane = addr[1:0]; half lane = addr[1] (addr[0] ignored); word ignores addr[1:0].
- Load extension:
  - Byte: bits [7:0] of the lane, extended with bit 7 if sign_mask[3], else zeros.
  - Half: same rule on 16 bits.
  - Word: passed through unchanged.
- read_data holds its last value outside load completion. Stores never change it.
- sign_mask with zero or multiple bits set in [2:0] is treated as word.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined:
  - Adds output misaligned (1 bit, reset 0).
  - A half access with addr[0] = 1, or a word access with addr[1:0] != 0, issues no memory transaction.
  - That access goes IDLE → DONE (one stall cycle). read_data is unchanged and misaligned = 1 for the DONE cycle only.
- Undefined: no port. Misaligned addresses are silently truncated as described under Lanes.

Decomposition:
- Shared package data_mem_pkg holds:
  - State enum.
  - Size one-hot constants SZ_BYTE = 3'b001, SZ_HALF = 3'b010, SZ_WORD = 3'b100.
  - SIGN_BIT index 3.
- One natural combinational sub-module, data_mem_lane, takes {word, addr[1:0], sign_mask, wr_data} and produces the extended load value and the merged store word. It is shared by the load and RMW paths.

Test Plan:
- Load byte, signed: mem word 32'h12_80_34_56, addr 0x...005, sign_mask 4'b1001, ack after 2 cycles → stall high 3 cycles; read_data = 32'h0000_0034 (lane 1 = 8'h34, positive).
- Same word, addr 0x...006, sign_mask 4'b1001 → read_data = 32'hFFFF_FF80. With sign_mask 4'b0001 → read_data = 32'h0000_0080.
- Store half: mem word 32'hAABB_CCDD, addr 0x...002, wr_data 32'h0000_1234, sign_mask 4'b0010 → one read then write with mem_wdata = 32'h1234_CCDD; read_data unchanged.
- Store word with ack after 1 cycle → exactly one mem_req with mem_we = 1, stall high 2 cycles, DONE, then IDLE. Back-to-back request → mem_req low for ≥1 cycle between transactions.
- rst_n pulsed low during RMW_WR wait → mem_req low asynchronously; after release state is IDLE and stall = 0; a stray mem_ack is ignored.
- MISALIGN_TRAP_EN defined: word load at addr 0x...001 → no mem_req, stall high 1 cycle, misaligned = 1 in DONE, read_data unchanged.
